// File: rtl/csh_sweep_pkg.sv
// Shared types and sizing helpers for the MBOX cache directory sweep sequencer.
package csh_sweep_pkg;

    typedef enum logic [1:0] {
        SW_VALIDATE = 2'b00,
        SW_UNLOAD   = 2'b01,
        SW_INVAL    = 2'b10,
        SW_SCAN     = 2'b11
    } sweep_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StChk,
        StWb,
        StWr,
        StNext,
        StDone
    } sweep_state_t;

    localparam int unsigned SweepSetsDflt = 128;
    localparam int unsigned SweepWaysDflt = 4;
    localparam int unsigned SweepTagwDflt = 13;

    function automatic int unsigned idx_width(input int unsigned sets, input int unsigned ways);
        return $clog2(sets * ways);
    endfunction

endpackage

// File: rtl/csh_sweep_idx_ctr.sv
// Sweep entry index: synchronous clear, increment, terminal-count flag; never wraps.
module csh_sweep_idx_ctr #(
    parameter int unsigned Width = 9,
    parameter int unsigned Last  = 511
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

    always_comb begin
        tc = (count == Width'(Last));
    end

endmodule

// File: rtl/csh_sweep.sv
// Cache sweep sequencer: walks every (set, way) directory entry and writes back
// and/or invalidates it according to the latched sweep op.
module csh_sweep
    import csh_sweep_pkg::*;
#(
    parameter int unsigned SETS = SweepSetsDflt,
    parameter int unsigned WAYS = SweepWaysDflt,
    parameter int unsigned TAGW = SweepTagwDflt
) (
    input  logic                    clk,
    input  logic                    RESET_N,
    input  logic                    start,
    input  sweep_op_t               op,
    input  logic                    page_en,
    input  logic [TAGW-1:0]         page,
    input  logic                    abort,
    output logic                    dir_rd,
    output logic [$clog2(SETS)-1:0] dir_set,
    output logic [$clog2(WAYS)-1:0] dir_way,
    input  logic                    dir_valid,
    input  logic                    dir_written,
    input  logic [TAGW-1:0]         dir_tag,
    output logic                    dir_wr,
    output logic                    dir_wr_valid,
    output logic                    dir_wr_written,
    output logic                    wb_req,
    input  logic                    wb_ack,
    input  logic                    wb_err,
    output logic                    SWEEP_BUSY_EN,
    output logic                    SWEEP_BUSY,
    output logic                    sweep_err
);

    localparam int unsigned ENTRIES = SETS * WAYS;
    localparam int unsigned IDXW    = idx_width(SETS, WAYS);
    localparam int unsigned SETW    = $clog2(SETS);
    localparam int unsigned WAYW    = $clog2(WAYS);

    sweep_state_t    state;
    sweep_op_t       op_q;
    logic            page_en_q;
    logic [TAGW-1:0] page_q;
    logic            abort_q;
    logic            wr_pend_q;
    logic            wr_vld_q;

    logic [IDXW-1:0] idx;
    logic            idx_tc;
    logic            idx_clr;
    logic            idx_inc;
    logic            match;
    logic            dirty;
    logic            need_wb;
    logic            need_wr;
    logic            finish;

    csh_sweep_idx_ctr #(
        .Width (IDXW),
        .Last  (ENTRIES - 1)
    ) u_idx_ctr (
        .clk     (clk),
        .RESET_N (RESET_N),
        .clr     (idx_clr),
        .inc     (idx_inc),
        .count   (idx),
        .tc      (idx_tc)
    );

    // Way occupies the low-order index bits.
    assign dir_set = idx[IDXW-1 -: SETW];
    assign dir_way = idx[WAYW-1:0];

    always_comb begin
        match   = dir_valid && (!page_en_q || (dir_tag == page_q));
        dirty   = match && dir_written;
        need_wb = dirty && ((op_q == SW_VALIDATE) || (op_q == SW_UNLOAD));
        need_wr = 1'b0;
        case (op_q)
            SW_VALIDATE: need_wr = dirty;
            SW_UNLOAD:   need_wr = match;
            SW_INVAL:    need_wr = match;
            default:     need_wr = 1'b0;
        endcase
        finish        = idx_tc || abort || abort_q;
        idx_clr       = (state == StIdle) && start;
        idx_inc       = (state == StNext) && !finish;
        SWEEP_BUSY_EN = (state != StIdle) && (state != StDone);
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= StIdle;
            op_q           <= SW_VALIDATE;
            page_en_q      <= 1'b0;
            page_q         <= '0;
            abort_q        <= 1'b0;
            wr_pend_q      <= 1'b0;
            wr_vld_q       <= 1'b0;
            dir_rd         <= 1'b0;
            dir_wr         <= 1'b0;
            dir_wr_valid   <= 1'b0;
            dir_wr_written <= 1'b0;
            wb_req         <= 1'b0;
            sweep_err      <= 1'b0;
        end else begin
            dir_rd         <= 1'b0;
            dir_wr         <= 1'b0;
            dir_wr_valid   <= 1'b0;
            dir_wr_written <= 1'b0;
            // Abort is deferred to the next NEXT so a write-back/write pair is never split.
            if (abort && SWEEP_BUSY_EN) abort_q <= 1'b1;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StRd;
                        dir_rd    <= 1'b1;
                        op_q      <= op;
                        page_en_q <= page_en;
                        page_q    <= page;
                        abort_q   <= 1'b0;
                        sweep_err <= 1'b0;
                    end
                end
                StRd: state <= StChk;
                StChk: begin
                    wr_pend_q <= need_wr;
                    wr_vld_q  <= (op_q == SW_VALIDATE);
                    if (need_wb) begin
                        state  <= StWb;
                        wb_req <= 1'b1;
                    end else if (need_wr) begin
                        state        <= StWr;
                        dir_wr       <= 1'b1;
                        dir_wr_valid <= (op_q == SW_VALIDATE);
                    end else begin
                        state <= StNext;
                    end
                end
                StWb: begin
                    if (wb_ack) begin
                        wb_req <= 1'b0;
                        if (wb_err) sweep_err <= 1'b1;
                        if (wr_pend_q) begin
                            state        <= StWr;
                            dir_wr       <= 1'b1;
                            dir_wr_valid <= wr_vld_q;
                        end else begin
                            state <= StNext;
                        end
                    end
                end
                StWr: state <= StNext;
                StNext: begin
                    if (finish) begin
                        state <= StDone;
                    end else begin
                        state  <= StRd;
                        dir_rd <= 1'b1;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            SWEEP_BUSY <= 1'b0;
        end else begin
            SWEEP_BUSY <= SWEEP_BUSY_EN;
        end
    end

endmodule

// File: tb/tb_csh_sweep.sv
// Directed and randomized sweeps of csh_sweep against an entry-level reference model.
module tb_csh_sweep;
    import csh_sweep_pkg::*;

    localparam int SETS = 4;
    localparam int WAYS = 2;
    localparam int TAGW = 13;
    localparam int N    = SETS * WAYS;

    logic                    clk;
    logic                    RESET_N;
    logic                    start;
    sweep_op_t               op;
    logic                    page_en;
    logic [TAGW-1:0]         page;
    logic                    abort;
    logic                    dir_rd;
    logic [$clog2(SETS)-1:0] dir_set;
    logic [$clog2(WAYS)-1:0] dir_way;
    logic                    dir_valid;
    logic                    dir_written;
    logic [TAGW-1:0]         dir_tag;
    logic                    dir_wr;
    logic                    dir_wr_valid;
    logic                    dir_wr_written;
    logic                    wb_req;
    logic                    wb_ack;
    logic                    wb_err;
    logic                    SWEEP_BUSY_EN;
    logic                    SWEEP_BUSY;
    logic                    sweep_err;

    csh_sweep #(
        .SETS (SETS),
        .WAYS (WAYS),
        .TAGW (TAGW)
    ) dut (
        .clk            (clk),
        .RESET_N        (RESET_N),
        .start          (start),
        .op             (op),
        .page_en        (page_en),
        .page           (page),
        .abort          (abort),
        .dir_rd         (dir_rd),
        .dir_set        (dir_set),
        .dir_way        (dir_way),
        .dir_valid      (dir_valid),
        .dir_written    (dir_written),
        .dir_tag        (dir_tag),
        .dir_wr         (dir_wr),
        .dir_wr_valid   (dir_wr_valid),
        .dir_wr_written (dir_wr_written),
        .wb_req         (wb_req),
        .wb_ack         (wb_ack),
        .wb_err         (wb_err),
        .SWEEP_BUSY_EN  (SWEEP_BUSY_EN),
        .SWEEP_BUSY     (SWEEP_BUSY),
        .sweep_err      (sweep_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Directory contents and responder settings
    logic [N-1:0]    mem_v, mem_w, err_e;
    logic [TAGW-1:0] mem_t [N];
    int              ack_dly;
    int              abort_at;

    // Observations
    int           rd_cnt, rd_bad, wr_dup, wb_unst, done_cnt, wb_cnt, wb_idx, last_hold;
    int           wb_set_seen, wb_way_seen;
    logic [N-1:0] wb_mask, wr_mask, wr_val, wr_wrt;
    logic         err_at_done;

    // Expectations
    logic [N-1:0] exp_wb, exp_wr, exp_val;
    logic         exp_err;
    int           exp_rd, exp_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, then act as directory and write-back port.
    task automatic tick();
        int e;
        @(negedge clk);
        e = int'({dir_set, dir_way});
        if (dir_rd) begin
            if (e != rd_cnt) rd_bad++;
            rd_cnt++;
            dir_valid   = mem_v[e];
            dir_written = mem_w[e];
            dir_tag     = mem_t[e];
        end
        if (dir_wr) begin
            if (wr_mask[e]) wr_dup++;
            wr_mask[e] = 1'b1;
            wr_val[e]  = dir_wr_valid;
            wr_wrt[e]  = dir_wr_written;
            mem_v[e]   = dir_wr_valid;
            mem_w[e]   = dir_wr_written;
        end
        if (wb_req) begin
            if (wb_cnt == 0) begin
                wb_idx      = e;
                wb_mask[e]  = 1'b1;
                wb_set_seen = int'(dir_set);
                wb_way_seen = int'(dir_way);
            end else if (e != wb_idx) begin
                wb_unst++;
            end
            wb_ack = (wb_cnt == ack_dly);
            wb_err = wb_ack && err_e[e];
            abort  = (e == abort_at);
            wb_cnt++;
            last_hold = wb_cnt;
        end else begin
            wb_cnt = 0;
            wb_ack = 1'b0;
            wb_err = 1'b0;
            abort  = 1'b0;
        end
        if (SWEEP_BUSY && !SWEEP_BUSY_EN) begin
            done_cnt++;
            err_at_done = sweep_err;
        end
    endtask

    // Entry-by-entry outcome of a sweep, straight from the op rules.
    task automatic predict(input sweep_op_t o, input logic pen, input logic [TAGW-1:0] pg);
        bit stop, m, d, wb, wr;
        stop = 0;
        exp_wb = '0; exp_wr = '0; exp_val = '0; exp_err = 1'b0; exp_rd = 0; exp_lat = 1;
        for (int e = 0; e < N; e++) begin
            if (!stop) begin
                m  = mem_v[e] && (!pen || mem_t[e] == pg);
                d  = m && mem_w[e];
                wb = d && (o == SW_VALIDATE || o == SW_UNLOAD);
                wr = (o == SW_VALIDATE && d) || (o == SW_UNLOAD && m) || (o == SW_INVAL && m);
                exp_rd++;
                exp_lat += 3 + (wb ? ack_dly + 1 : 0) + (wr ? 1 : 0);
                exp_wb[e]  = wb;
                exp_wr[e]  = wr;
                exp_val[e] = wr && (o == SW_VALIDATE);
                if (wb && err_e[e]) exp_err = 1'b1;
                if (wb && e == abort_at) stop = 1;
            end
        end
    endtask

    task automatic clear_obs();
        rd_cnt = 0; rd_bad = 0; wr_dup = 0; wb_unst = 0; done_cnt = 0; wb_cnt = 0;
        last_hold = 0; wb_set_seen = -1; wb_way_seen = -1;
        wb_mask = '0; wr_mask = '0; wr_val = '0; wr_wrt = '0; err_at_done = 1'b0;
    endtask

    task automatic run_sweep(input string nm, input sweep_op_t o, input logic pen,
                             input logic [TAGW-1:0] pg, input bit mid_start);
        int  lat;
        bit  busy;
        predict(o, pen, pg);
        clear_obs();
        op = o; page_en = pen; page = pg; start = 1'b1;
        lat = 0; busy = 1;
        while (busy && lat < 1000) begin
            tick();
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                chk({nm, ".err_clr"}, 32'(sweep_err), 0);
            end
            if (mid_start && lat == 4) begin
                start = 1'b1; op = SW_INVAL; page_en = 1'b0;
            end
            if (mid_start && lat == 5) start = 1'b0;
            busy = SWEEP_BUSY_EN;
        end
        chk({nm, ".ended"}, 32'(busy), 0);
        for (int k = 0; k < 3; k++) tick();
        chk({nm, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, ".rd_cnt"}, 32'(rd_cnt), 32'(exp_rd));
        chk({nm, ".rd_order"}, 32'(rd_bad), 0);
        chk({nm, ".wb_mask"}, 32'(wb_mask), 32'(exp_wb));
        chk({nm, ".wb_stable"}, 32'(wb_unst), 0);
        chk({nm, ".wr_mask"}, 32'(wr_mask), 32'(exp_wr));
        chk({nm, ".wr_valid"}, 32'(wr_val), 32'(exp_val));
        chk({nm, ".wr_written"}, 32'(wr_wrt), 0);
        chk({nm, ".wr_dup"}, 32'(wr_dup), 0);
        chk({nm, ".done_win"}, 32'(done_cnt), 1);
        chk({nm, ".err_done"}, 32'(err_at_done), 32'(exp_err));
        chk({nm, ".err_idle"}, 32'(sweep_err), 32'(exp_err));
    endtask

    task automatic blank_dir();
        mem_v = '0; mem_w = '0; err_e = '0;
        for (int e = 0; e < N; e++) mem_t[e] = '0;
        abort_at = -1;
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({dir_rd, dir_wr, dir_wr_valid, dir_wr_written, wb_req, SWEEP_BUSY_EN,
                    SWEEP_BUSY, sweep_err, dir_set, dir_way});
    endfunction

    initial begin
        int n;
        RESET_N = 1'b1; start = 1'b0; op = SW_VALIDATE; page_en = 1'b0; page = '0; abort = 1'b0;
        dir_valid = 1'b0; dir_written = 1'b0; dir_tag = '0; wb_ack = 1'b0; wb_err = 1'b0;
        ack_dly = 0;
        blank_dir();
        clear_obs();
        #3 RESET_N = 1'b0;
        #1 chk("reset.outputs", outs_vec(), 0);
        tick(); tick();
        RESET_N = 1'b1;
        tick();
        chk("reset.idle", outs_vec(), 0);

        // 1: all invalid, scan: 3 clks per entry plus one
        blank_dir(); ack_dly = 0;
        run_sweep("t1", SW_SCAN, 1'b0, '0, 1'b0);
        chk("t1.lat_const", 32'(exp_lat), 32'(3 * N + 1));

        // 2: validate, entry 5 dirty, ack three clocks late
        blank_dir(); ack_dly = 3;
        mem_v[0] = 1'b1;
        mem_v[5] = 1'b1; mem_w[5] = 1'b1;
        run_sweep("t2", SW_VALIDATE, 1'b0, '0, 1'b0);
        chk("t2.wb_hold", 32'(last_hold), 4);
        chk("t2.wb_set", 32'(wb_set_seen), 2);
        chk("t2.wb_way", 32'(wb_way_seen), 1);

        // 3: page-restricted unload
        blank_dir(); ack_dly = 1;
        mem_v[1] = 1'b1; mem_t[1] = 13'h12;
        mem_v[6] = 1'b1; mem_w[6] = 1'b1; mem_t[6] = 13'h12;
        mem_v[3] = 1'b1; mem_w[3] = 1'b1; mem_t[3] = 13'h34;
        run_sweep("t3", SW_UNLOAD, 1'b1, 13'h12, 1'b0);
        chk("t3.wb_const", 32'(wb_mask), 32'h40);
        chk("t3.wr_const", 32'(wr_mask), 32'h42);

        // 4: write-back error on entry 3
        blank_dir(); ack_dly = 0;
        mem_v[3] = 1'b1; mem_w[3] = 1'b1; err_e[3] = 1'b1;
        run_sweep("t4", SW_VALIDATE, 1'b0, '0, 1'b0);
        chk("t4.err_const", 32'(sweep_err), 1);

        // 5: abort in WB on entry 2, with an ignored start mid-sweep
        blank_dir(); ack_dly = 2; abort_at = 2;
        mem_v[2] = 1'b1; mem_w[2] = 1'b1;
        mem_v[5] = 1'b1; mem_w[5] = 1'b1;
        run_sweep("t5", SW_VALIDATE, 1'b0, '0, 1'b1);
        chk("t5.rd_const", 32'(rd_cnt), 3);

        // 6: reset while holding wb_req
        blank_dir(); ack_dly = 50;
        mem_v[2] = 1'b1; mem_w[2] = 1'b1;
        clear_obs();
        op = SW_VALIDATE; page_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!wb_req && n < 100) begin
            tick();
            n++;
        end
        chk("t6.wb_seen", 32'(wb_req), 1);
        wr_mask = '0; done_cnt = 0;
        #2 RESET_N = 1'b0;
        #1 chk("t6.rst_outputs", outs_vec(), 0);
        tick();
        RESET_N = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("t6.no_wr", 32'(wr_mask), 0);
        chk("t6.no_done", 32'(done_cnt), 0);
        chk("t6.idle", 32'(SWEEP_BUSY_EN), 0);

        // Randomized sweeps
        for (int r = 0; r < 10; r++) begin
            for (int e = 0; e < N; e++) begin
                mem_v[e] = 1'($urandom_range(0, 1));
                mem_w[e] = 1'($urandom_range(0, 1));
                mem_t[e] = ($urandom_range(0, 1) == 1) ? 13'h12 : 13'h34;
                err_e[e] = ($urandom_range(0, 5) == 0);
            end
            ack_dly  = int'($urandom_range(0, 3));
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            run_sweep($sformatf("rnd%0d", r), sweep_op_t'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? 13'h12 : 13'h34, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
